// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks a two-road one-hot {R,Y,G} light bus for encoding, conflict,
// colour order and dwell violations, latching a fault with sticky flags.
module traffic_light_monitor #(
    parameter int CNT_W      = 32,
    parameter int MIN_RED    = 2,
    parameter int MIN_YELLOW = 2,
    parameter int MIN_GREEN  = 2,
    parameter int MAX_DWELL  = 20_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  main_road,
    input  logic [2:0]  side_road,
    input  logic        fault_clr,
    output logic        fault,
    output logic [4:0]  err_flags,
    output logic [2:0]  first_err,
    output logic [15:0] cycles_done
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [CNT_W-1:0] DMAX = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] DONE = CNT_W'(1);

    typedef enum logic [1:0] {SYNC, RUN, FLT} state_t;

    state_t           r_state, w_state;
    logic [2:0]       r_col   [2];
    logic [2:0]       w_col   [2];
    logic [CNT_W-1:0] r_dwell [2];
    logic [CNT_W-1:0] w_dwell [2];
    logic [2:0]       w_road  [2];
    logic [1:0]       r_armed, w_armed, r_valid, w_valid, w_ok;
    logic [4:0]       r_flags, w_flags, w_err;
    logic [2:0]       r_first, w_first;
    logic [15:0]      r_cycles, w_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= SYNC;
            r_col    <= '{default: '0};
            r_dwell  <= '{default: '0};
            r_armed  <= '0;
            r_valid  <= '0;
            r_flags  <= '0;
            r_first  <= '0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state;
            r_col    <= w_col;
            r_dwell  <= w_dwell;
            r_armed  <= w_armed;
            r_valid  <= w_valid;
            r_flags  <= w_flags;
            r_first  <= w_first;
            r_cycles <= w_cycles;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_col    = r_col;
        w_dwell  = r_dwell;
        w_armed  = r_armed;
        w_valid  = r_valid;
        w_flags  = r_flags;
        w_first  = r_first;
        w_cycles = r_cycles;
        w_err    = '0;
        w_road[0] = main_road;
        w_road[1] = side_road;
        for (int i = 0; i < 2; i++)
            w_ok[i] = (w_road[i] == RED) || (w_road[i] == YEL) || (w_road[i] == GRN);
        if (r_state == SYNC) begin
            if (&w_ok) begin
                for (int i = 0; i < 2; i++) begin
                    w_col[i]   = w_road[i];
                    w_dwell[i] = DONE;
                    w_armed[i] = 1'b0;
                    w_valid[i] = 1'b1;
                end
                w_state = RUN;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_ok[i]) begin
                    w_err[0]   = 1'b1;
                    w_valid[i] = 1'b0;
                end else if (!r_valid[i]) begin
                    w_col[i]   = w_road[i];
                    w_dwell[i] = DONE;
                    w_armed[i] = 1'b0;
                    w_valid[i] = 1'b1;
                end else if (w_road[i] == r_col[i]) begin
                    if (r_dwell[i] == DMAX) w_err[4] = 1'b1;
                    else w_dwell[i] = r_dwell[i] + DONE;
                end else begin
                    if (!((r_col[i] == RED && w_road[i] == YEL) ||
                          (r_col[i] == YEL && w_road[i] == GRN) ||
                          (r_col[i] == GRN && w_road[i] == RED))) w_err[2] = 1'b1;
                    if (r_armed[i] && r_dwell[i] < (r_col[i] == RED ? CNT_W'(MIN_RED) :
                        r_col[i] == YEL ? CNT_W'(MIN_YELLOW) : CNT_W'(MIN_GREEN))) w_err[3] = 1'b1;
                    w_col[i]   = w_road[i];
                    w_dwell[i] = DONE;
                    w_armed[i] = 1'b1;
                end
            end
            w_err[1] = &w_ok && !main_road[2] && !side_road[2];
            if (w_ok[0] && r_valid[0] && r_col[0] == RED && main_road == YEL && r_cycles != 16'hFFFF)
                w_cycles = r_cycles + 16'd1;
            w_flags = r_flags | w_err;
            if (r_state == RUN && |w_err) begin
                w_state = FLT;
                w_first = w_err[0] ? 3'd1 : w_err[1] ? 3'd2 : w_err[2] ? 3'd3 : w_err[3] ? 3'd4 : 3'd5;
            end
        end
        // clear wins over anything detected on the same sample
        if (fault_clr) begin
            w_state  = SYNC;
            w_flags  = '0;
            w_first  = '0;
            w_cycles = '0;
            w_valid  = '0;
            w_armed  = '0;
            w_dwell  = '{default: '0};
        end
    end

    assign fault       = (r_state == FLT);
    assign err_flags   = r_flags;
    assign first_err   = r_first;
    assign cycles_done = r_cycles;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed vectors with a queued expected-response scoreboard.
module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct {
        logic        f;
        logic [4:0]  fl;
        logic [2:0]  fe;
        logic [15:0] cy;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  main_road = R;
    logic [2:0]  side_road = R;
    logic        fault_clr = 1'b1;
    logic        fault;
    logic [4:0]  err_flags;
    logic [2:0]  first_err;
    logic [15:0] cycles_done;
    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    traffic_light_monitor #(.MAX_DWELL(8)) dut (
        .clk(clk), .rst(rst), .main_road(main_road), .side_road(side_road),
        .fault_clr(fault_clr), .fault(fault), .err_flags(err_flags),
        .first_err(first_err), .cycles_done(cycles_done)
    );

    always #5 clk = ~clk;

    task automatic ap(input logic [2:0] m, input logic [2:0] s, input logic c, input logic ef,
                      input logic [4:0] efl, input logic [2:0] efe, input logic [15:0] ecy,
                      input string nm);
        exp_t e;
        @(negedge clk);
        main_road = m;
        side_road = s;
        fault_clr = c;
        e.f = ef; e.fl = efl; e.fe = efe; e.cy = ecy; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        n_vec++;
        if ({fault, err_flags, first_err, cycles_done} !== 25'd0) begin
            n_bad++;
            $display("FAIL %s: got fault=%b flags=%b first=%0d cycles=%0d, want all zero",
                     nm, fault, err_flags, first_err, cycles_done);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if ({fault, err_flags, first_err, cycles_done} !== {e.f, e.fl, e.fe, e.cy}) begin
                n_bad++;
                $display("FAIL %s: got fault=%b flags=%b first=%0d cycles=%0d, want fault=%b flags=%b first=%0d cycles=%0d",
                         e.nm, fault, err_flags, first_err, cycles_done, e.f, e.fl, e.fe, e.cy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // legal loop, side mirrored while main is red
        ap(R, R, 0, 0, 5'b0, 0, 0, "legal_load");
        ap(R, Y, 0, 0, 5'b0, 0, 0, "legal_2");
        ap(R, Y, 0, 0, 5'b0, 0, 0, "legal_3");
        ap(R, G, 0, 0, 5'b0, 0, 0, "legal_4");
        ap(R, G, 0, 0, 5'b0, 0, 0, "legal_5");
        ap(R, R, 0, 0, 5'b0, 0, 0, "legal_6");
        ap(Y, R, 0, 0, 5'b0, 0, 1, "legal_main_ry1");
        ap(Y, R, 0, 0, 5'b0, 0, 1, "legal_8");
        ap(Y, R, 0, 0, 5'b0, 0, 1, "legal_9");
        ap(G, R, 0, 0, 5'b0, 0, 1, "legal_10");
        ap(G, R, 0, 0, 5'b0, 0, 1, "legal_11");
        ap(G, R, 0, 0, 5'b0, 0, 1, "legal_12");
        ap(R, R, 0, 0, 5'b0, 0, 1, "legal_side_dwell_max");
        ap(R, Y, 0, 0, 5'b0, 0, 1, "legal_14");
        ap(R, Y, 0, 0, 5'b0, 0, 1, "legal_15");
        ap(R, G, 0, 0, 5'b0, 0, 1, "legal_16");
        ap(R, G, 0, 0, 5'b0, 0, 1, "legal_17");
        ap(R, R, 0, 0, 5'b0, 0, 1, "legal_18");
        ap(Y, R, 0, 0, 5'b0, 0, 2, "legal_main_ry2");
        ap(Y, R, 0, 0, 5'b0, 0, 2, "legal_20");
        ap(R, R, 1, 0, 5'b0, 0, 0, "clr_run");
        // encoding error, then unarmed resync
        ap(R, R, 0, 0, 5'b0, 0, 0, "enc_load");
        ap(3'b110, R, 0, 1, 5'b00001, 1, 0, "enc");
        ap(R, R, 0, 1, 5'b00001, 1, 0, "enc_resync");
        ap(R, R, 0, 1, 5'b00001, 1, 0, "enc_r2");
        ap(Y, R, 0, 1, 5'b00001, 1, 1, "enc_y_noshort");
        ap(G, R, 0, 1, 5'b01001, 1, 1, "short_in_fault");
        ap(R, R, 1, 0, 5'b0, 0, 0, "clr_fault");
        // conflict
        ap(G, Y, 0, 0, 5'b0, 0, 0, "conf_load");
        ap(G, Y, 0, 1, 5'b00010, 2, 0, "conflict");
        ap(R, R, 1, 0, 5'b0, 0, 0, "clr_conf");
        // SEQ and CONFLICT on one sample: lowest index wins
        ap(R, R, 0, 0, 5'b0, 0, 0, "multi_load");
        ap(G, Y, 0, 1, 5'b00110, 2, 0, "seq_conf_same");
        ap(R, R, 1, 0, 5'b0, 0, 0, "clr_multi");
        // armed out-of-order change
        ap(G, R, 0, 0, 5'b0, 0, 0, "seq_load");
        ap(G, R, 0, 0, 5'b0, 0, 0, "seq_g2");
        ap(R, R, 0, 0, 5'b0, 0, 0, "seq_gr_unarmed");
        ap(R, R, 0, 0, 5'b0, 0, 0, "seq_r2");
        ap(G, R, 0, 1, 5'b00100, 3, 0, "seq_rg");
        ap(R, R, 1, 0, 5'b0, 0, 0, "clr_seq");
        // armed yellow too short
        ap(G, R, 0, 0, 5'b0, 0, 0, "short_load");
        ap(R, R, 0, 0, 5'b0, 0, 0, "short_r1");
        ap(R, R, 0, 0, 5'b0, 0, 0, "short_r2");
        ap(Y, R, 0, 0, 5'b0, 0, 1, "short_y1");
        ap(G, R, 0, 1, 5'b01000, 4, 1, "short");
        ap(R, R, 1, 0, 5'b0, 0, 0, "clr_short");
        // dwell limit: 8 samples legal, 9th is STUCK
        ap(R, R, 0, 0, 5'b0, 0, 0, "stuck_load");
        for (int i = 2; i <= 8; i++) ap(R, R, 0, 0, 5'b0, 0, 0, $sformatf("dwell_%0d", i));
        ap(R, R, 0, 1, 5'b10000, 5, 0, "stuck");
        ap(R, R, 0, 1, 5'b10000, 5, 0, "stuck_again");
        ap(G, Y, 1, 0, 5'b0, 0, 0, "clr_beats_conflict");
        ap(G, Y, 0, 0, 5'b0, 0, 0, "sync_no_check");
        ap(G, Y, 0, 1, 5'b00010, 2, 0, "conflict_before_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        fault_clr = 1'b1;
        #1 chk_zero("rst_mid_fault");
        @(negedge clk);
        rst = 1'b0;
        ap(R, R, 0, 0, 5'b0, 0, 0, "post_rst_load");
        ap(Y, R, 0, 0, 5'b0, 0, 1, "post_rst_ry");
        ap(Y, R, 0, 0, 5'b0, 0, 1, "post_rst_y2");
        ap(G, R, 0, 0, 5'b0, 0, 1, "post_rst_g1");
        ap(G, R, 0, 0, 5'b0, 0, 1, "post_rst_g2");
        ap(R, R, 0, 0, 5'b0, 0, 1, "post_rst_gr");
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
